// File: rtl/bulk_in_packetiser.sv
// bulk_in_packetiser: chops a byte stream into USB bulk-IN packets, closing them on the size limit,
// s_tlast, idle timeout or flush, and inserts a ZLP after full-size packets that end a transfer.
module bulk_in_packetiser #(
  parameter int MAX_PKT_HS = 512,
  parameter int MAX_PKT_FS = 64,
  parameter int TIMEOUT    = 1024,
  parameter bit ZLP_ENABLE = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        high_speed_i,
  input  logic        flush_i,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic [7:0]  s_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tkeep,
  output logic [7:0]  m_tdata,
  output logic [15:0] packets_o,
  output logic        zlp_o
);
  localparam int CW = $clog2(MAX_PKT_HS + 1);
  localparam int IW = $clog2(TIMEOUT);
  logic          h_valid, h_last, rdy_en, flush_seen, zlp_pending;
  logic [7:0]    h_data;
  logic [CW-1:0] cnt, lim, lim_cur;
  logic [IW-1:0] idle;
  logic          o_free, idle_expired, close, acc, xfer, zlp_go, zlp_acc;
  // the limit is only taken from high_speed_i on the first byte of a packet
  always_comb begin
    lim_cur      = cnt == '0 ? (high_speed_i ? CW'(MAX_PKT_HS) : CW'(MAX_PKT_FS)) : lim;
    o_free       = !m_tvalid || m_tready;
    idle_expired = idle == IW'(TIMEOUT - 1);
    close        = h_last || cnt == lim_cur - CW'(1) || idle_expired || flush_seen;
    s_tready     = rdy_en && (!h_valid || (o_free && !zlp_pending));
    acc          = s_tvalid && s_tready;
    xfer         = h_valid && o_free && !zlp_pending && (s_tvalid || close);
    zlp_go       = zlp_pending && o_free;
    zlp_acc      = m_tvalid && m_tready && !m_tkeep;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdy_en      <= 1'b0;
      h_valid     <= 1'b0;
      h_last      <= 1'b0;
      h_data      <= 8'h00;
      idle        <= '0;
      flush_seen  <= 1'b0;
      zlp_pending <= 1'b0;
      cnt         <= '0;
      lim         <= '0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_tkeep     <= 1'b0;
      m_tdata     <= 8'h00;
      packets_o   <= 16'h0000;
      zlp_o       <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (acc) begin
        h_valid <= 1'b1;
        h_data  <= s_tdata;
        h_last  <= s_tlast;
      end else if (xfer) h_valid <= 1'b0;
      idle <= (acc || xfer) ? '0 : (h_valid && !s_tvalid && !idle_expired) ? idle + IW'(1) : idle;
      // a flush with nothing held and no open packet has nothing to close
      flush_seen <= (xfer && close) ? 1'b0 : flush_seen || (flush_i && (h_valid || cnt != '0));
      if (xfer) begin
        m_tvalid    <= 1'b1;
        m_tdata     <= h_data;
        m_tkeep     <= 1'b1;
        m_tlast     <= close;
        cnt         <= close ? '0 : cnt + CW'(1);
        lim         <= lim_cur;
        zlp_pending <= ZLP_ENABLE && h_last && cnt == lim_cur - CW'(1);
      end else if (zlp_go) begin
        m_tvalid    <= 1'b1;
        m_tdata     <= 8'h00;
        m_tkeep     <= 1'b0;
        m_tlast     <= 1'b1;
        zlp_pending <= 1'b0;
      end else if (m_tready) m_tvalid <= 1'b0;
      packets_o <= packets_o + 16'(xfer && close) + 16'(zlp_acc);
      zlp_o     <= zlp_acc;
    end
  end
endmodule

// File: tb/tb_bulk_in_packetiser.sv
// tb_bulk_in_packetiser: randomized bench checking output beats against a per-transfer packet model
module tb_bulk_in_packetiser;
  localparam int TO = 1024;
  logic clock = 1'b0, reset_n = 1'b0, high_speed_i = 1'b1, flush_i = 1'b0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic s_tready, m_tvalid, m_tlast, m_tkeep, zlp_o;
  logic [7:0] m_tdata;
  logic [15:0] packets_o;
  bulk_in_packetiser #(.MAX_PKT_HS(512), .MAX_PKT_FS(64), .TIMEOUT(TO), .ZLP_ENABLE(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .high_speed_i(high_speed_i), .flush_i(flush_i),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tkeep(m_tkeep),
    .m_tdata(m_tdata), .packets_o(packets_o), .zlp_o(zlp_o)
  );
  always #5 clock = ~clock;
  int n_chk = 0, n_pass = 0, cyc = 0, duty = 100;
  int exp_pk = 0, exp_zlp = 0, zlp_cnt = 0, beats = 0, last_cyc = 0, acc_cyc = 0;
  logic [9:0] expq[$];
  logic [9:0] held;
  bit stall = 0, zlp_next = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) begin
    #1 m_tready = $urandom_range(0, 99) < duty;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // mode 0: transfer still open (held byte not expected), 1: closed by flush/timeout, 2: ended by s_tlast
  task automatic add_transfer(input int n, input int lim, input int start, input int mode);
    for (int i = 0; i < n; i++) begin
      bit last;
      if (mode == 0 && i == n - 1) break;
      last = ((i + 1) % lim == 0) || (i == n - 1);
      expq.push_back({1'b1, last, 8'(start + i)});
      if (last) exp_pk++;
    end
    if (mode == 2 && n % lim == 0) begin
      expq.push_back(10'h100);
      exp_pk++;
      exp_zlp++;
    end
  endtask
  always @(negedge clock) begin
    logic [9:0] b, e;
    b = {m_tkeep, m_tlast, m_tdata};
    if (reset_n) begin
      if (stall) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_beat", b, held);
      end
      check("zlp_o", zlp_o, zlp_next);
      if (zlp_o) zlp_cnt++;
      zlp_next = 0;
      stall = m_tvalid && !m_tready;
      held = b;
      if (m_tvalid && m_tready) begin
        beats++;
        if (expq.size() == 0) check("extra_beat", {1'b1, b}, 0);
        else begin
          e = expq.pop_front();
          check("beat", b, e);
          if (!e[9]) zlp_next = 1;
          if (e[8]) last_cyc = cyc;
        end
      end
    end else begin
      stall = 0;
      zlp_next = 0;
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic push(input logic [7:0] d, input bit l);
    bit ok;
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata = d;
    s_tlast = l;
    do begin
      @(negedge clock);
      ok = s_tready;
      @(posedge clock);
      #1;
      n++;
    end while (!ok && n < 2000);
    if (!ok) check("push_timeout", n, 0);
    acc_cyc = cyc;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask
  task automatic send_seq(input int n, input int start, input bit last_end, input bit gaps);
    for (int i = 0; i < n; i++) begin
      push(8'(start + i), last_end && i == n - 1);
      if (gaps && $urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
    end
  endtask
  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 30000) begin
      tick(1);
      n++;
    end
    check("drain", expq.size(), 0);
    tick(2);
  endtask
  initial begin
    int total, len, seq, fcyc, b0;
    bit hs;
    tick(3);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tkeep", m_tkeep, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_packets", packets_o, 0);
    check("rst_zlp_o", zlp_o, 0);
    reset_n = 1'b1;
    check("rdy_before_edge", s_tready, 0);
    tick(1);
    check("rdy_after_edge", s_tready, 1);
    // HS stream of 1030 bytes ending in tlast
    add_transfer(1030, 512, 0, 2);
    send_seq(1030, 0, 1'b1, 1'b0);
    drain();
    check("hs1030_packets", packets_o, exp_pk);
    check("hs1030_zlp", zlp_cnt, exp_zlp);
    // exactly one full HS packet ending in tlast
    add_transfer(512, 512, 0, 2);
    send_seq(512, 0, 1'b1, 1'b0);
    drain();
    check("hs512_packets", packets_o, exp_pk);
    check("hs512_zlp", zlp_cnt, exp_zlp);
    // FS short packet closed by idle timeout
    high_speed_i = 1'b0;
    add_transfer(10, 64, 8'h40, 1);
    send_seq(10, 8'h40, 1'b0, 1'b0);
    tick(100);
    check("fs_held", expq.size(), 1);
    drain();
    check("timeout_latency", last_cyc - acc_cyc, TO);
    check("fs_packets", packets_o, exp_pk);
    high_speed_i = 1'b1;
    // flush closes a held short packet
    add_transfer(3, 512, 8'h80, 1);
    send_seq(3, 8'h80, 1'b0, 1'b0);
    tick(5);
    check("flush_held", expq.size(), 1);
    flush_i = 1'b1;
    tick(1);
    fcyc = cyc;
    flush_i = 1'b0;
    drain();
    check("flush_latency", 32'(last_cyc > fcyc && last_cyc - fcyc <= 2), 1);
    b0 = beats;
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
    tick(20);
    check("empty_flush_beats", beats, b0);
    check("empty_flush_packets", packets_o, exp_pk);
    add_transfer(2, 512, 8'h90, 2);
    send_seq(2, 8'h90, 1'b1, 1'b0);
    drain();
    check("post_flush_packets", packets_o, exp_pk);
    // random back-pressure over mixed-speed transfers
    duty = 30;
    total = 0;
    seq = 8'h33;
    while (total < 5000) begin
      len = $urandom_range(0, 3);
      len = len == 0 ? 512 : len == 1 ? 64 : len == 2 ? 1024 : $urandom_range(1, 700);
      if (len > 5000 - total) len = 5000 - total;
      hs = $urandom_range(0, 1);
      high_speed_i = hs;
      add_transfer(len, hs ? 512 : 64, seq, 2);
      send_seq(len, seq, 1'b1, 1'b1);
      seq += len;
      total += len;
    end
    drain();
    duty = 100;
    high_speed_i = 1'b1;
    tick(2);
    check("rand_packets", packets_o, exp_pk);
    check("rand_zlp", zlp_cnt, exp_zlp);
    // reset in the middle of an open packet
    add_transfer(100, 512, 0, 0);
    send_seq(100, 0, 1'b0, 1'b0);
    tick(1);
    check("pre_reset_out", expq.size(), 0);
    reset_n = 1'b0;
    tick(1);
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_packets", packets_o, 0);
    check("mid_rst_s_tready", s_tready, 0);
    reset_n = 1'b1;
    exp_pk = 0;
    tick(1);
    add_transfer(512, 512, 8'h11, 2);
    send_seq(512, 8'h11, 1'b1, 1'b0);
    drain();
    check("post_rst_packets", packets_o, exp_pk);
    check("post_rst_zlp", zlp_cnt, exp_zlp);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
